if_stage_bp: RTL and testbench
==============================

Name: if_stage_bp

Overview:
- Parameterised instruction-fetch stage. Holds the PC, forms the fetch address for an external combinational instruction memory, and registers the IF/ID pipeline outputs.
- Adds dynamic branch prediction: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Adds flush/redirect from decode (jump) and execute (branch resolution / mispredict), plus stall support.
- Sits between the PC source logic and the ID stage of the 5-stage pipeline.

Parameters:
- ADDR_W, 32, PC/address width in bits (>= IDX_W+3).
- INSTR_W, 32, instruction width.
- BTB_ENTRIES, 16, BTB depth; power of 2, >= 2. IDX_W = log2(BTB_ENTRIES).
- RESET_PC, 0, PC value after reset.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- WriteEnable  in  1  1 = advance PC and IF/ID; 0 = stall (hold).
- FetchAddr  out  ADDR_W  current PC, drives instruction memory address.
- InstrIn  in  INSTR_W  instruction read combinationally at FetchAddr.
- Jump  in  1  decode-stage jump; redirect to JumpDest.
- JumpDest  in  ADDR_W  jump target.
- Redirect  in  1  EX-stage mispredict; redirect to RedirectPC.
- RedirectPC  in  ADDR_W  corrected PC.
- ResolveValid  in  1  EX has resolved a conditional branch this cycle.
- ResolvePC  in  ADDR_W  PC of the resolved branch.
- ResolveTaken  in  1  actual branch outcome.
- ResolveTarget  in  ADDR_W  actual taken target.
- Instruction  out  INSTR_W  IF/ID registered instruction.
- PC_Out  out  ADDR_W  IF/ID registered PC of that instruction.
- PredTaken  out  1  IF/ID registered prediction.
- PredTarget  out  ADDR_W  IF/ID registered predicted target.
- Valid  out  1  IF/ID slot holds a real instruction (0 = bubble).

Behaviour:
- Index and tag: idx = PC[IDX_W+1:2]; tag = PC[ADDR_W-1:IDX_W+2]. Each entry holds valid, tag, target and a 2-bit counter.
- Lookup (combinational on FetchAddr): hit = valid && tag match. pred_taken = hit && ctr[1]. pred_next = pred_taken ? target : FetchAddr+4. Addition wraps modulo 2^ADDR_W.
- Next-PC priority, highest first:
  - Reset → RESET_PC.
  - Redirect → RedirectPC.
  - Jump → JumpDest.
  - !WriteEnable → hold PC.
  - Otherwise → pred_next.
- Redirect and Jump override a stall: the PC loads even when WriteEnable=0.
- IF/ID registers:
  - Reset → all outputs 0, Valid=0.
  - Redirect or Jump (asserted together or separately) → Valid=0 (flush). Instruction, PC_Out, PredTaken and PredTarget are 0.
  - Else if !WriteEnable → hold all IF/ID outputs.
  - Else → capture InstrIn, FetchAddr, pred_taken, pred_next; Valid=1.
- Latency: the instruction fetched at PC appears on IF/ID outputs 1 cycle later. The first valid instruction is the cycle after Reset deasserts.
- BTB update occurs on the Clock edge when ResolveValid=1 and Reset=0. It happens regardless of WriteEnable, Jump or Redirect. Index and tag come from ResolvePC.
  - Tag hit: ctr increments if taken (saturate at 11), decrements if not taken (saturate at 00). On taken, target ← ResolveTarget.
  - Miss and taken: allocate by overwriting the entry. valid=1, tag set, target=ResolveTarget, ctr=10.
  - Miss and not taken: no change.
- Lookup and update on the same index in the same cycle: the lookup sees the pre-update contents. The update is visible the next cycle.
- Reset: all BTB valid bits 0 and counters 01. PC=RESET_PC. Reset mid-operation discards any in-flight update in that cycle.
- FetchAddr equals the PC register directly, with no combinational path from inputs.

Test Plan:
- Reset held 2 cycles, then release with InstrIn=PC-derived pattern, WriteEnable=1 → FetchAddr 0,4,8,C. The IF/ID PC_Out lags by 1 cycle. Valid=0 during reset and 1 from cycle 1.
- WriteEnable=0 for 3 cycles at PC=0x10 → FetchAddr stays 0x10 and IF/ID outputs are frozen. Resume → 0x14 next.
- ResolveValid, ResolvePC=0x20, Taken=1, Target=0x80 (allocates, ctr=10) → next fetch at 0x20 gives PredTaken=1, PredTarget=0x80, and the following FetchAddr=0x80.
- Same branch resolved not-taken twice (ctr 10→01→00) → fetch at 0x20 predicts not-taken, next FetchAddr=0x24. Three further taken resolutions → ctr saturates at 11, and one not-taken leaves a taken prediction.
- Redirect=1, RedirectPC=0x100 together with Jump=1, JumpDest=0x200, while WriteEnable=0 → FetchAddr=0x100 next cycle, Valid=0 for one cycle.
- Aliasing: 0x20 allocated taken, then 0x20+4*BTB_ENTRIES resolved taken to 0x300 → 0x20 now misses (predicts PC+4), and the alias predicts 0x300. Also check PC wrap from 0xFFFFFFFC → 0x0.

Source files
------------

// File: rtl/if_stage_bp.sv
// if_stage_bp: instruction-fetch stage with a direct-mapped BTB and 2-bit counter branch prediction
//   clk_i             Clock, rising edge
//   rst_i             Reset, synchronous active-high
//   write_enable_i    WriteEnable: 1 = advance PC and IF/ID, 0 = stall
//   fetch_addr_o      FetchAddr: current PC, drives instruction memory address
//   instr_i           InstrIn: instruction read combinationally at fetch_addr_o
//   jump_i/jump_dest_i          Jump / JumpDest from decode
//   redirect_i/redirect_pc_i    Redirect / RedirectPC from execute
//   resolve_*_i       ResolveValid/PC/Taken/Target: branch outcome from execute
//   instruction_o, pc_o, pred_taken_o, pred_target_o, valid_o: IF/ID register outputs
module if_stage_bp #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int BTB_ENTRIES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               write_enable_i,
  output logic [ADDR_W-1:0]  fetch_addr_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               jump_i,
  input  logic [ADDR_W-1:0]  jump_dest_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic               resolve_valid_i,
  input  logic [ADDR_W-1:0]  resolve_pc_i,
  input  logic               resolve_taken_i,
  input  logic [ADDR_W-1:0]  resolve_target_i,
  output logic [INSTR_W-1:0] instruction_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               pred_taken_o,
  output logic [ADDR_W-1:0]  pred_target_o,
  output logic               valid_o
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              btb_v_q   [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q [BTB_ENTRIES];
  logic [ADDR_W-1:0] btb_tgt_q [BTB_ENTRIES];
  logic [1:0]        btb_ctr_q [BTB_ENTRIES];

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               pt_q, pt_d;
  logic [ADDR_W-1:0]  ptgt_q, ptgt_d;
  logic               valid_q, valid_d;

  logic [IDX_W-1:0]  l_idx, r_idx;
  logic [TAG_W-1:0]  l_tag, r_tag;
  logic              l_hit, r_hit, pred_taken, flush;
  logic [ADDR_W-1:0] pred_next;
  logic [1:0]        ctr_upd;
  logic              unused_lsb;

  assign unused_lsb = ^resolve_pc_i[1:0];

  assign l_idx = pc_q[IDX_W+1:2];
  assign l_tag = pc_q[ADDR_W-1:IDX_W+2];
  assign l_hit = btb_v_q[l_idx] && btb_tag_q[l_idx] == l_tag;
  assign pred_taken = l_hit && btb_ctr_q[l_idx][1];
  assign pred_next = pred_taken ? btb_tgt_q[l_idx] : pc_q + ADDR_W'(4);

  assign r_idx = resolve_pc_i[IDX_W+1:2];
  assign r_tag = resolve_pc_i[ADDR_W-1:IDX_W+2];
  assign r_hit = btb_v_q[r_idx] && btb_tag_q[r_idx] == r_tag;

  // Saturating counter step for the resolving entry
  always_comb begin
    ctr_upd = btb_ctr_q[r_idx];
    if (resolve_taken_i && ctr_upd != 2'b11) ctr_upd = ctr_upd + 2'd1;
    else if (!resolve_taken_i && ctr_upd != 2'b00) ctr_upd = ctr_upd - 2'd1;
  end

  assign flush = redirect_i || jump_i;

  // Redirect and Jump win over a stall; a stall only holds the sequential path
  always_comb begin
    pc_d     = redirect_i ? redirect_pc_i : jump_i ? jump_dest_i : !write_enable_i ? pc_q : pred_next;
    instr_d  = flush ? '0 : !write_enable_i ? instr_q : instr_i;
    pc_out_d = flush ? '0 : !write_enable_i ? pc_out_q : pc_q;
    pt_d     = flush ? 1'b0 : !write_enable_i ? pt_q : pred_taken;
    ptgt_d   = flush ? '0 : !write_enable_i ? ptgt_q : pred_next;
    valid_d  = flush ? 1'b0 : !write_enable_i ? valid_q : 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      pt_q     <= 1'b0;
      ptgt_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      pt_q     <= pt_d;
      ptgt_q   <= ptgt_d;
      valid_q  <= valid_d;
    end
  end

  // BTB update is independent of stall/flush; a miss allocates only on taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_v_q[i]   <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_ctr_q[i] <= 2'b01;
      end
    end else if (resolve_valid_i) begin
      if (r_hit) begin
        btb_ctr_q[r_idx] <= ctr_upd;
        if (resolve_taken_i) btb_tgt_q[r_idx] <= resolve_target_i;
      end else if (resolve_taken_i) begin
        btb_v_q[r_idx]   <= 1'b1;
        btb_tag_q[r_idx] <= r_tag;
        btb_tgt_q[r_idx] <= resolve_target_i;
        btb_ctr_q[r_idx] <= 2'b10;
      end
    end
  end

  assign fetch_addr_o  = pc_q;
  assign instruction_o = instr_q;
  assign pc_o          = pc_out_q;
  assign pred_taken_o  = pt_q;
  assign pred_target_o = ptgt_q;
  assign valid_o       = valid_q;
endmodule

// File: tb/tb_if_stage_bp.sv
// tb_if_stage_bp: directed self-checking bench for if_stage_bp
module tb_if_stage_bp;
  logic        clk = 1'b0;
  logic        rst, we, jump, redirect, rv, rt;
  logic [31:0] jdest, rpc, rpcv, rtgt, instr;
  logic [31:0] fetch, instr_o, pc_o, ptgt;
  logic        ptaken, valid;
  int          tests = 0;
  int          fails = 0;

  if_stage_bp dut (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we), .fetch_addr_o(fetch), .instr_i(instr),
    .jump_i(jump), .jump_dest_i(jdest), .redirect_i(redirect), .redirect_pc_i(rpc),
    .resolve_valid_i(rv), .resolve_pc_i(rpcv), .resolve_taken_i(rt), .resolve_target_i(rtgt),
    .instruction_o(instr_o), .pc_o(pc_o), .pred_taken_o(ptaken), .pred_target_o(ptgt),
    .valid_o(valid)
  );

  always #5 clk = ~clk;
  assign instr = ~fetch;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_jump(input logic [31:0] d);
    jump = 1; jdest = d;
    step();
    jump = 0;
  endtask

  initial begin
    rst = 1; we = 1; jump = 0; redirect = 0; rv = 0; rt = 0;
    jdest = 0; rpc = 0; rpcv = 0; rtgt = 0;
    step(); step();
    check("rst_fetch", fetch, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    rst = 0;
    step();
    check("seq0_fetch", fetch, 32'h4);
    check("seq0_valid", {31'd0, valid}, 32'd1);
    check("seq0_pc", pc_o, 32'h0);
    check("seq0_instr", instr_o, 32'hFFFF_FFFF);
    check("seq0_ptaken", {31'd0, ptaken}, 32'd0);
    check("seq0_ptgt", ptgt, 32'h4);
    step(); check("seq1_fetch", fetch, 32'h8); check("seq1_pc", pc_o, 32'h4);
    step(); check("seq2_fetch", fetch, 32'hC); check("seq2_pc", pc_o, 32'h8);
    step(); check("seq3_fetch", fetch, 32'h10); check("seq3_pc", pc_o, 32'hC);
    we = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_fetch", fetch, 32'h10);
      check("stall_pc", pc_o, 32'hC);
      check("stall_instr", instr_o, ~32'hC);
      check("stall_valid", {31'd0, valid}, 32'd1);
    end
    we = 1;
    step(); check("resume_fetch", fetch, 32'h14); check("resume_pc", pc_o, 32'h10);
    rv = 1; rpcv = 32'h20; rt = 1; rtgt = 32'h80;
    do_jump(32'h20);
    rv = 0;
    check("alloc_fetch", fetch, 32'h20);
    check("alloc_flush", {31'd0, valid}, 32'd0);
    step();
    check("alloc_pc", pc_o, 32'h20);
    check("alloc_ptaken", {31'd0, ptaken}, 32'd1);
    check("alloc_ptgt", ptgt, 32'h80);
    check("alloc_next", fetch, 32'h80);
    rv = 1; rt = 0;
    step(); step();
    rv = 0;
    do_jump(32'h20);
    step();
    check("nt_ptaken", {31'd0, ptaken}, 32'd0);
    check("nt_ptgt", ptgt, 32'h24);
    check("nt_next", fetch, 32'h24);
    rv = 1; rt = 1;
    for (int i = 0; i < 4; i++) step();
    rt = 0;
    step();
    rv = 0;
    do_jump(32'h20);
    step();
    check("sat_ptaken", {31'd0, ptaken}, 32'd1);
    check("sat_next", fetch, 32'h80);
    we = 0; redirect = 1; rpc = 32'h100; jump = 1; jdest = 32'h200;
    step();
    redirect = 0; jump = 0;
    check("redir_fetch", fetch, 32'h100);
    check("redir_valid", {31'd0, valid}, 32'd0);
    check("redir_pc", pc_o, 32'h0);
    check("redir_ptaken", {31'd0, ptaken}, 32'd0);
    we = 1;
    step();
    check("redir_resume_fetch", fetch, 32'h104);
    check("redir_resume_pc", pc_o, 32'h100);
    check("redir_resume_valid", {31'd0, valid}, 32'd1);
    rv = 1; rt = 1; rpcv = 32'h60; rtgt = 32'h300;
    step();
    rv = 0;
    do_jump(32'h20);
    step();
    check("alias_orig_ptaken", {31'd0, ptaken}, 32'd0);
    check("alias_orig_next", fetch, 32'h24);
    do_jump(32'h60);
    step();
    check("alias_new_ptaken", {31'd0, ptaken}, 32'd1);
    check("alias_new_ptgt", ptgt, 32'h300);
    check("alias_new_next", fetch, 32'h300);
    do_jump(32'hFFFF_FFFC);
    step();
    check("wrap_fetch", fetch, 32'h0);
    check("wrap_pc", pc_o, 32'hFFFF_FFFC);
    check("wrap_ptgt", ptgt, 32'h0);
    do_jump(32'h70);
    rv = 1; rt = 1; rpcv = 32'h70; rtgt = 32'h900;
    step();
    rv = 0;
    check("same_cycle_ptaken", {31'd0, ptaken}, 32'd0);
    check("same_cycle_next", fetch, 32'h74);
    do_jump(32'h70);
    step();
    check("after_update_ptaken", {31'd0, ptaken}, 32'd1);
    check("after_update_next", fetch, 32'h900);
    rst = 1; rv = 1; rt = 1; rpcv = 32'h40; rtgt = 32'h500;
    step();
    rst = 0; rv = 0;
    check("rst2_fetch", fetch, 32'h0);
    check("rst2_valid", {31'd0, valid}, 32'd0);
    do_jump(32'h40);
    step();
    check("rst2_drop_ptaken", {31'd0, ptaken}, 32'd0);
    check("rst2_drop_next", fetch, 32'h44);
    do_jump(32'h60);
    step();
    check("rst2_cleared", fetch, 32'h64);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
